// File: rtl/uart_pkg.sv
// Shared UART constants used by the receive front end and the baud generator.
package uart_pkg;

    // Samples taken per bit period.
    localparam int OVERSAMPLE          = 16;

    // A break is a low line lasting a whole 10-bit character.
    localparam int DEFAULT_BREAK_TICKS = 10 * OVERSAMPLE;

    // The line counts as idle after one full bit time of high level.
    localparam int DEFAULT_IDLE_TICKS  = OVERSAMPLE;

endpackage : uart_pkg

// File: rtl/uart_rx_frontend_if.sv
// Control and status bundle between the receive front end and its neighbours.
interface uart_rx_frontend_if
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = 16
);

    logic                 enable;
    logic [DIV_WIDTH-1:0] baud_div;
    logic                 baud_div_load;
    logic                 serial_in;
    logic                 sample_tick;
    logic                 serial_data_out;
    logic                 start_edge;
    logic                 idle_detect;
    logic                 break_detect;

    // The side that configures the block and supplies the raw line.
    modport master (
        output enable,
        output baud_div,
        output baud_div_load,
        output serial_in,
        input  sample_tick,
        input  serial_data_out,
        input  start_edge,
        input  idle_detect,
        input  break_detect
    );

    // The front end itself.
    modport slave (
        input  enable,
        input  baud_div,
        input  baud_div_load,
        input  serial_in,
        output sample_tick,
        output serial_data_out,
        output start_edge,
        output idle_detect,
        output break_detect
    );

endinterface : uart_rx_frontend_if

// File: rtl/uart_baud_gen.sv
// Programmable oversampling tick generator; shared by the receiver and transmitter.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    input  logic [DIV_WIDTH-1:0] i_baud_div,
    input  logic                 i_baud_div_load,
    output logic                 o_wrap,
    output logic                 o_sample_tick
);

    logic [DIV_WIDTH-1:0] r_shadow;
    logic [DIV_WIDTH-1:0] r_count;
    logic                 r_sample_tick;
    logic [DIV_WIDTH-1:0] w_last_count;

    // A zero divisor behaves as one, so the terminal count is never below zero.
    always_comb begin
        w_last_count = '0;
        if (r_shadow != '0) begin
            w_last_count = r_shadow - DIV_WIDTH'(1);
        end
    end

    // Wrap strobe: a load in the same cycle suppresses it.
    assign o_wrap        = i_enable & ~i_baud_div_load & (r_count == w_last_count);
    assign o_sample_tick = r_sample_tick;

    // Shadow divisor, free-running counter and registered tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow      <= DIV_WIDTH'(1);
            r_count       <= '0;
            r_sample_tick <= 1'b0;
        end else if (i_baud_div_load) begin
            r_shadow      <= i_baud_div;
            r_count       <= '0;
            r_sample_tick <= 1'b0;
        end else if (!i_enable) begin
            r_count       <= '0;
            r_sample_tick <= 1'b0;
        end else if (o_wrap) begin
            r_count       <= '0;
            r_sample_tick <= 1'b1;
        end else begin
            r_count       <= r_count + DIV_WIDTH'(1);
            r_sample_tick <= 1'b0;
        end
    end

endmodule : uart_baud_gen

// File: rtl/uart_rx_frontend.sv
// RX line front end: synchroniser, tick generation, majority filter and line-state detectors.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int BREAK_TICKS = DEFAULT_BREAK_TICKS,
    parameter int IDLE_TICKS  = DEFAULT_IDLE_TICKS
) (
    input  logic               sys_clk,
    input  logic               reset_n,
    uart_rx_frontend_if.slave  bus
);

    localparam int LOW_W  = $clog2(BREAK_TICKS + 1);
    localparam int HIGH_W = $clog2(IDLE_TICKS + 1);
    localparam int ONES_W = $clog2(FILTER_LEN + 1);

    localparam logic [LOW_W-1:0]  LOW_MAX  = LOW_W'(BREAK_TICKS);
    localparam logic [HIGH_W-1:0] HIGH_MAX = HIGH_W'(IDLE_TICKS);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FILTER_LEN-1:0]  r_window;
    logic                   r_data_out;
    logic                   r_start_edge;
    logic                   r_idle_detect;
    logic                   r_break_detect;
    logic [LOW_W-1:0]       r_low_run;
    logic [HIGH_W-1:0]      r_high_run;

    logic                   w_sync;
    logic                   w_wrap;
    logic                   w_tick;
    logic [FILTER_LEN-1:0]  w_window_next;
    logic [ONES_W-1:0]      w_ones;
    logic                   w_maj;
    logic [LOW_W-1:0]       w_low_next;
    logic [HIGH_W-1:0]      w_high_next;

    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_gen (
        .i_clk           (sys_clk),
        .i_rst_n         (reset_n),
        .i_enable        (bus.enable),
        .i_baud_div      (bus.baud_div),
        .i_baud_div_load (bus.baud_div_load),
        .o_wrap          (w_wrap),
        .o_sample_tick   (w_tick)
    );

    // Shift the raw line through the synchroniser chain; idle-high at reset.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.serial_in};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Window as it will look after this tick; bit 0 holds the newest sample.
    generate
        if (FILTER_LEN == 1) begin : g_win_single
            assign w_window_next = w_sync;
        end else begin : g_win_shift
            assign w_window_next = {r_window[FILTER_LEN-2:0], w_sync};
        end
    endgenerate

    // Count ones in the new window; the level is whichever value holds a majority.
    always_comb begin
        w_ones = '0;
        for (int i = 0; i < FILTER_LEN; i++) begin
            w_ones = w_ones + ONES_W'(w_window_next[i]);
        end
    end

    assign w_maj = (int'(w_ones) > (FILTER_LEN / 2));

    // Saturating run lengths seen with the freshly filtered level.
    always_comb begin
        w_low_next  = '0;
        w_high_next = '0;
        if (w_maj) begin
            w_high_next = (r_high_run == HIGH_MAX) ? r_high_run : r_high_run + HIGH_W'(1);
        end else begin
            w_low_next  = (r_low_run == LOW_MAX) ? r_low_run : r_low_run + LOW_W'(1);
        end
    end

    // Filter, edge and line-state tracking, advanced only on sample ticks.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_window       <= '1;
            r_data_out     <= 1'b1;
            r_start_edge   <= 1'b0;
            r_idle_detect  <= 1'b0;
            r_break_detect <= 1'b0;
            r_low_run      <= '0;
            r_high_run     <= '0;
        end else if (w_wrap) begin
            r_window      <= w_window_next;
            r_data_out    <= w_maj;
            r_start_edge  <= r_data_out & ~w_maj;
            r_idle_detect <= (r_high_run != HIGH_MAX) && (w_high_next == HIGH_MAX);
            r_low_run     <= w_low_next;
            r_high_run    <= w_high_next;
            if (w_maj) begin
                r_break_detect <= 1'b0;
            end else if (w_low_next == LOW_MAX) begin
                r_break_detect <= 1'b1;
            end
        end else begin
            r_start_edge  <= 1'b0;
            r_idle_detect <= 1'b0;
        end
    end

    assign bus.sample_tick     = w_tick;
    assign bus.serial_data_out = r_data_out;
    assign bus.start_edge      = r_start_edge;
    assign bus.idle_detect     = r_idle_detect;
    assign bus.break_detect    = r_break_detect;

endmodule : uart_rx_frontend

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: directed table, corner sequences, random run.
module tb_uart_rx_frontend;
    import uart_pkg::*;

    localparam int DW = 16;
    localparam int SS = 2;
    localparam int FL = 3;
    localparam int BT = 160;
    localparam int IT = 16;

    logic sys_clk = 1'b0;
    logic reset_n = 1'b1;

    always #5 sys_clk = ~sys_clk;

    uart_rx_frontend_if #(.DIV_WIDTH(DW)) bus_if ();

    uart_rx_frontend #(
        .DIV_WIDTH   (DW),
        .SYNC_STAGES (SS),
        .FILTER_LEN  (FL),
        .BREAK_TICKS (BT),
        .IDLE_TICKS  (IT)
    ) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: line history and run lengths as plain numbers.
    int m_div;
    int m_elapsed;
    bit m_sync[$];
    bit m_win[$];
    bit m_tick, m_out, m_start, m_idle, m_brk;
    int m_low, m_high;

    function automatic void model_reset();
        m_div = 1;
        m_elapsed = 0;
        m_sync = {};
        m_win = {};
        for (int i = 0; i < SS; i++) m_sync.push_back(1'b1);
        for (int i = 0; i < FL; i++) m_win.push_back(1'b1);
        m_tick = 0; m_out = 1; m_start = 0; m_idle = 0; m_brk = 0;
        m_low = 0; m_high = 0;
    endfunction

    // One clock edge: the tick falls on every div-th enabled cycle since the last restart.
    function automatic void model_edge(input bit en, input bit ld, input int div, input bit sin);
        bit wsync;
        bit wrap;
        bit maj;
        int eff;
        int ones;
        int prev_high;
        wsync = m_sync[SS-1];
        m_sync.push_front(sin);
        void'(m_sync.pop_back());
        eff  = (m_div == 0) ? 1 : m_div;
        wrap = 0;
        if (ld) begin
            m_div = div; m_elapsed = 0; m_tick = 0;
        end else if (!en) begin
            m_elapsed = 0; m_tick = 0;
        end else begin
            m_elapsed++;
            wrap = ((m_elapsed % eff) == 0);
            m_tick = wrap;
        end
        if (wrap) begin
            m_win.push_front(wsync);
            void'(m_win.pop_back());
            ones = 0;
            foreach (m_win[i]) ones += m_win[i];
            maj = (ones * 2 > FL);
            m_start = m_out && !maj;
            m_out = maj;
            if (maj) begin
                prev_high = m_high;
                m_high = (m_high < IT) ? m_high + 1 : IT;
                m_idle = (prev_high < IT) && (m_high == IT);
                m_low = 0;
                m_brk = 0;
            end else begin
                m_low = (m_low < BT) ? m_low + 1 : BT;
                if (m_low == BT) m_brk = 1;
                m_high = 0;
                m_idle = 0;
            end
        end else begin
            m_start = 0;
            m_idle = 0;
        end
    endfunction

    function automatic logic [4:0] dut_vec();
        return {bus_if.sample_tick, bus_if.serial_data_out, bus_if.start_edge,
                bus_if.idle_detect, bus_if.break_detect};
    endfunction

    function automatic void check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Apply inputs, advance one clock and compare every output with the model.
    task automatic step(input bit en, input bit ld, input int div, input bit sin, input string tag);
        logic [4:0] exp;
        logic [4:0] act;
        bus_if.enable        = en;
        bus_if.baud_div_load = ld;
        bus_if.baud_div      = DW'(div);
        bus_if.serial_in     = sin;
        model_edge(en, ld, div, sin);
        @(posedge sys_clk);
        #1;
        exp = {m_tick, m_out, m_start, m_idle, m_brk};
        act = dut_vec();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: tick/out/start/idle/brk got %b, expected %b", tag, $time, act, exp);
        end
    endtask

    // Asynchronous reset applied between edges; outputs must clear immediately.
    task automatic do_reset(input string tag);
        bus_if.baud_div_load = 1'b0;
        reset_n = 1'b0;
        #1;
        check_int({tag, "_async"}, int'(dut_vec()), 5'b01000);
        @(posedge sys_clk);
        #1;
        check_int({tag, "_held"}, int'(dut_vec()), 5'b01000);
        reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit en;
        int div;
        bit lvl;
        int ncyc;
        int exp_ticks;   // -1: not checked
        int exp_starts;
        int exp_idles;
        bit exp_out;
        bit exp_brk;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Long windows keep every expected pulse clear of the segment boundaries.
        vecs[0]  = '{1, 4, 1,  80,  19, 0, 1, 1, 0};  // load, first idle after 16 ticks
        vecs[1]  = '{1, 4, 0,   1,  -1, 0, 0, 1, 0};  // one-cycle glitch
        vecs[2]  = '{1, 4, 1,  40,  10, 0, 0, 1, 0};  // glitch is filtered out
        vecs[3]  = '{1, 4, 0,  40,  10, 1, 0, 0, 0};  // real low: one start edge
        vecs[4]  = '{1, 4, 1, 100,  25, 0, 1, 1, 0};  // back high: idle re-armed
        vecs[5]  = '{1, 4, 0, 680, 170, 1, 0, 0, 1};  // 170 low ticks: break
        vecs[6]  = '{1, 4, 1, 100,  25, 0, 1, 1, 0};  // break clears, idle follows
        vecs[7]  = '{1, 1, 1,  20,  19, 0, 0, 1, 0};  // div 1: tick every cycle after load
        vecs[8]  = '{1, 1, 0,  20,  20, 1, 0, 0, 0};
        vecs[9]  = '{1, 1, 1,  30,  30, 0, 1, 1, 0};
        vecs[10] = '{0, 1, 1,  40,   0, 0, 0, 1, 0};  // disabled: no ticks
        vecs[11] = '{1, 1, 1,  10,  10, 0, 0, 1, 0};  // re-enable restarts ticks
    end

    initial begin
        int t1, t2, ti, nt, ns, cur_div;
        int ticks, starts, idles;
        bit ld;
        int div, len, lvl, en;
        bit [7:0] data;

        bus_if.enable        = 1'b0;
        bus_if.baud_div      = '0;
        bus_if.baud_div_load = 1'b0;
        bus_if.serial_in     = 1'b1;
        model_reset();
        #2;
        reset_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        check_int("reset_state", int'(dut_vec()), 5'b01000);
        reset_n = 1'b1;

        // Divisor 4: first tick 4 cycles after load, period 4, idle at tick 16.
        step(1, 1, 4, 1, "A_load");
        t1 = -1; t2 = -1; ti = -1;
        for (int i = 1; i <= 100; i++) begin
            step(1, 0, 4, 1, "A_run");
            if (bus_if.sample_tick) begin
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
            end
            if (bus_if.idle_detect && ti < 0) ti = i;
        end
        check_int("A_first_tick", t1, 4);
        check_int("A_second_tick", t2, 8);
        check_int("A_first_idle", ti, 64);
        $display("seq A: first tick %0d, second %0d, idle %0d", t1, t2, ti);

        // Divisor 1 and 0 both tick every cycle; the load edge itself never ticks.
        step(1, 1, 1, 1, "B_load1");
        check_int("B_load1_no_tick", int'(bus_if.sample_tick), 0);
        nt = 0;
        for (int i = 0; i < 8; i++) begin step(1, 0, 1, 1, "B_div1"); nt += bus_if.sample_tick; end
        check_int("B_div1_ticks", nt, 8);
        step(1, 1, 0, 1, "B_load0");
        check_int("B_load0_no_tick", int'(bus_if.sample_tick), 0);
        nt = 0;
        for (int i = 0; i < 8; i++) begin step(1, 0, 0, 1, "B_div0"); nt += bus_if.sample_tick; end
        check_int("B_div0_ticks", nt, 8);
        $display("seq B: div1/div0 tick every cycle checked");

        // Load of 8 lands exactly on the would-be wrap of divisor 4.
        step(1, 1, 4, 1, "C_load4");
        for (int i = 0; i < 3; i++) step(1, 0, 4, 1, "C_count");
        step(1, 1, 8, 1, "C_load8");
        check_int("C_load_beats_wrap", int'(bus_if.sample_tick), 0);
        t1 = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1, 0, 8, 1, "C_run");
            if (bus_if.sample_tick && t1 < 0) t1 = i;
        end
        check_int("C_first_tick_div8", t1, 8);
        $display("seq C: first tick after reload at %0d", t1);

        // Reset in the middle of a low frame.
        step(1, 1, 4, 0, "D_load");
        for (int i = 0; i < 30; i++) step(1, 0, 4, 0, "D_low");
        check_int("D_low_before_reset", int'(bus_if.serial_data_out), 0);
        do_reset("D_reset");
        $display("seq D: mid-frame reset checked");

        // Directed table.
        bus_if.enable = 1'b0;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, "T_pre");
        do_reset("T_reset");
        cur_div = 1;
        foreach (vecs[v]) begin
            ticks = 0; starts = 0; idles = 0;
            for (int c = 0; c < vecs[v].ncyc; c++) begin
                ld = (c == 0) && vecs[v].en && (vecs[v].div != cur_div);
                step(vecs[v].en, ld, vecs[v].div, vecs[v].lvl, $sformatf("T%0d", v));
                ticks  += bus_if.sample_tick;
                starts += bus_if.start_edge;
                idles  += bus_if.idle_detect;
            end
            if (vecs[v].en) cur_div = vecs[v].div;
            if (vecs[v].exp_ticks >= 0) check_int($sformatf("T%0d_ticks", v), ticks, vecs[v].exp_ticks);
            check_int($sformatf("T%0d_starts", v), starts, vecs[v].exp_starts);
            check_int($sformatf("T%0d_idles", v), idles, vecs[v].exp_idles);
            check_int($sformatf("T%0d_out", v), int'(bus_if.serial_data_out), int'(vecs[v].exp_out));
            check_int($sformatf("T%0d_brk", v), int'(bus_if.break_detect), int'(vecs[v].exp_brk));
            $display("vec %0d: lvl=%0d cycles=%0d ticks=%0d starts=%0d idles=%0d out=%b brk=%b",
                     v, vecs[v].lvl, vecs[v].ncyc, ticks, starts, idles,
                     bus_if.serial_data_out, bus_if.break_detect);
        end

        // 0x55 frame, 8N1, 16 ticks per bit at divisor 4: five filtered falling edges.
        step(1, 1, 4, 1, "E_load");
        for (int i = 0; i < 100; i++) step(1, 0, 4, 1, "E_idle");
        data = 8'h55;
        ns = 0;
        for (int b = 0; b < 10; b++) begin
            lvl = (b == 0) ? 0 : (b == 9) ? 1 : int'(data[b-1]);
            for (int c = 0; c < 64; c++) begin
                step(1, 0, 4, lvl[0], "E_frame");
                ns += bus_if.start_edge;
            end
        end
        for (int i = 0; i < 100; i++) begin
            step(1, 0, 4, 1, "E_tail");
            ns += bus_if.start_edge;
        end
        check_int("E_start_edges", ns, 5);
        $display("seq E: frame 0x55 start edges %0d", ns);

        // Randomised segments checked cycle by cycle against the model.
        do_reset("R_reset");
        for (int s = 0; s < 60; s++) begin
            en  = ($urandom_range(0, 9) != 0);
            ld  = ($urandom_range(0, 3) == 0);
            div = $urandom_range(0, 6);
            lvl = $urandom_range(0, 1);
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 200);
            if ($urandom_range(0, 19) == 0) do_reset("R_midreset");
            for (int c = 0; c < len; c++) begin
                step(en[0], ld && (c == 0), ld ? div : m_div, lvl[0], "R");
            end
            $display("rand %0d: en=%0d ld=%0d div=%0d lvl=%0d len=%0d out=%b brk=%b",
                     s, en, ld, div, lvl, len, bus_if.serial_data_out, bus_if.break_detect);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_uart_rx_frontend
